// File: rtl/field_locator.sv
// Maps a mouse click to the 1-based (column,row) of the board field under it.
// The division by the field pitch is done by repeated subtraction, one step per cycle per axis.
module field_locator (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  level,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        click,
    input  logic [10:0] board_xpos,
    input  logic [10:0] board_ypos,
    input  logic [6:0]  button_size,
    input  logic [4:0]  board_size,
    output logic [4:0]  field_ind_x,
    output logic [4:0]  field_ind_y,
    output logic        valid,
    output logic        out_of_board,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, DONE} state_t;

    state_t      state_q, state_d;
    logic        click_q;
    logic        armed_q;
    logic [11:0] mx_q, mx_d, my_q, my_d;
    logic [10:0] bx_q, bx_d, by_q, by_d;
    logic [6:0]  bsz_q, bsz_d;
    logic [4:0]  nsz_q, nsz_d;
    logic [11:0] rem_x_q, rem_x_d, rem_y_q, rem_y_d;
    logic [4:0]  q_x_q, q_x_d, q_y_q, q_y_d;
    logic [4:0]  ind_x_q, ind_x_d, ind_y_q, ind_y_d;
    logic        oob_q, oob_d;

    logic        click_edge;
    logic [11:0] dx, dy, extent, pitch;

    // armed_q blocks the first cycle after reset release, so a click held across release is not a request.
    assign click_edge = click & ~click_q & armed_q;

    assign dx     = mx_q - {1'b0, bx_q};
    assign dy     = my_q - {1'b0, by_q};
    assign extent = 12'(nsz_q) * 12'(bsz_q);
    assign pitch  = {5'd0, bsz_q};

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        mx_d    = mx_q;
        my_d    = my_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bsz_d   = bsz_q;
        nsz_d   = nsz_q;
        rem_x_d = rem_x_q;
        rem_y_d = rem_y_q;
        q_x_d   = q_x_q;
        q_y_d   = q_y_q;
        ind_x_d = ind_x_q;
        ind_y_d = ind_y_q;
        oob_d   = oob_q;

        case (state_q)
            IDLE: begin
                if (click_edge && level != 2'd0) begin
                    mx_d    = mouse_xpos;
                    my_d    = mouse_ypos;
                    bx_d    = board_xpos;
                    by_d    = board_ypos;
                    bsz_d   = button_size;
                    nsz_d   = board_size;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mx_q < {1'b0, bx_q} || my_q < {1'b0, by_q} ||
                    dx >= extent || dy >= extent || bsz_q == 7'd0) begin
                    oob_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_x_d = dx;
                    rem_y_d = dy;
                    q_x_d   = 5'd0;
                    q_y_d   = 5'd0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                if (rem_x_q < pitch && rem_y_q < pitch) begin
                    // Outputs change only on entry to DONE so they hold steady between valid pulses.
                    ind_x_d = q_x_q + 5'd1;
                    ind_y_d = q_y_q + 5'd1;
                    oob_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    if (rem_x_q >= pitch) begin
                        rem_x_d = rem_x_q - pitch;
                        q_x_d   = q_x_q + 5'd1;
                    end
                    if (rem_y_q >= pitch) begin
                        rem_y_d = rem_y_q - pitch;
                        q_y_d   = q_y_q + 5'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            click_q <= 1'b0;
            armed_q <= 1'b0;
            mx_q    <= '0;
            my_q    <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bsz_q   <= '0;
            nsz_q   <= '0;
            rem_x_q <= '0;
            rem_y_q <= '0;
            q_x_q   <= '0;
            q_y_q   <= '0;
            ind_x_q <= '0;
            ind_y_q <= '0;
            oob_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
            state_q <= state_d;
            click_q <= click;
            armed_q <= 1'b1;
            mx_q    <= mx_d;
            my_q    <= my_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bsz_q   <= bsz_d;
            nsz_q   <= nsz_d;
            rem_x_q <= rem_x_d;
            rem_y_q <= rem_y_d;
            q_x_q   <= q_x_d;
            q_y_q   <= q_y_d;
            ind_x_q <= ind_x_d;
            ind_y_q <= ind_y_d;
            oob_q   <= oob_d;
        end
    end

    assign valid        = (state_q == DONE);
    assign busy         = (state_q != IDLE);
    assign field_ind_x  = ind_x_q;
    assign field_ind_y  = ind_y_q;
    assign out_of_board = oob_q;

endmodule

// File: doc/field_locator.md
FIELD_LOCATOR -- requirements
Module: field_locator

Interface
REQ-001 clk  input  1  system pixel clock; all state on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, released synchronously to clk.
REQ-003 level  input  2  difficulty; 0 = no game in progress.
REQ-004 mouse_xpos  input  12  cursor x in pixels.
REQ-005 mouse_ypos  input  12  cursor y in pixels.
REQ-006 click  input  1  left-button level; a request is its 0->1 transition.
REQ-007 board_xpos  input  11  board top-left x in pixels.
REQ-008 board_ypos  input  11  board top-left y in pixels.
REQ-009 button_size  input  7  field pitch in pixels.
REQ-010 board_size  input  5  fields per board side, 1..31.
REQ-011 field_ind_x  output  5  column of clicked field, 1-based (1 = leftmost).
REQ-012 field_ind_y  output  5  row of clicked field, 1-based (1 = top).
REQ-013 valid  output  1  one-cycle pulse; indices/out_of_board are updated in this cycle.
REQ-014 out_of_board  output  1  last request was outside the board or rejected.
REQ-015 busy  output  1  high while a request is in progress (any state except IDLE).

Function
REQ-016 Module SHALL be the inverse of the field-to-pixel mapping: field index i covers pixels board_pos + (i-1)*button_size .. board_pos + i*button_size - 1 on each axis.
REQ-017 Click edge SHALL be detected as click & ~click_q, click_q a registered copy of click; a held click SHALL produce exactly one request.
REQ-018 FSM states SHALL be IDLE, CHECK, DIVIDE, DONE.
REQ-019 IDLE: on edge with level != 0, capture mouse_xpos/ypos, board_xpos/ypos, button_size, board_size into registers, go CHECK; edges with level == 0 SHALL be ignored.
REQ-020 Edges while busy SHALL be ignored (no queueing).
REQ-021 CHECK: dx = mx - bx, dy = my - by, extent = board_size * button_size (12-bit, max 3937); if mx < bx, my < by, dx >= extent, dy >= extent, or button_size == 0, set out_of_board=1 and go DONE; else load rem_x=dx, rem_y=dy, q_x=q_y=0, out_of_board=0, go DIVIDE.
REQ-022 DIVIDE: each cycle, per axis independently, if rem >= button_size then rem -= button_size and q += 1; when both rem < button_size at cycle start, go DONE with no change.
REQ-023 DONE: valid=1 for exactly that cycle; if not out_of_board, field_ind_x = q_x + 1, field_ind_y = q_y + 1; return to IDLE.
REQ-024 Latency from the cycle the edge is sampled in IDLE (cycle N): valid at N+2 when out_of_board, else N+3+max(q_x,q_y).
REQ-025 On out_of_board, field_ind_x/y SHALL hold their previous values.
REQ-026 field_ind_x/y and out_of_board SHALL hold between valid pulses.
REQ-027 Inputs other than click/level SHALL be ignored after capture; changes mid-request do not affect the result.

Reset
REQ-028 On rst=0: state=IDLE, click_q=0, field_ind_x=0, field_ind_y=0, valid=0, out_of_board=0, busy=0, internal quotient/remainder registers 0.
REQ-029 Reset asserted mid-DIVIDE SHALL abort the request with no valid pulse; the first edge after release starts a fresh request.
REQ-030 A click held high across reset release SHALL NOT produce a request (click_q sampled from click on first cycle after release, edge requires click_q=0).

Verification
REQ-031 board (100,50), size 30, board_size 8, level 1; click rising at mouse (100,50) -> valid at N+3, ind (1,1), out_of_board 0.
REQ-032 same board; click at (339,289) -> valid at N+10, ind (8,8); click at (130,79) -> ind (2,1).
REQ-033 same board; click at (340,60) and at (99,60) -> each valid at N+2, out_of_board 1, indices unchanged from previous result.
REQ-034 click held high 100 cycles at (160,110) -> exactly one valid, ind (3,3); second edge during busy -> ignored, still one valid.
REQ-035 level 0 click -> no busy, no valid; button_size 0, level 1 -> valid at N+2, out_of_board 1.
REQ-036 rst pulsed low during DIVIDE -> all outputs 0 immediately, no valid; next click at (100,50) -> ind (1,1) at N+3.
